// File: rtl/axil_reg_slice_if.sv
// AXI-Lite channel bundle between arbiter, register slice and slave.
// master drives requests and response-readies; slave drives the rest.
interface axi_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic                    aw_valid;
  logic                    aw_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_valid;
  logic                    w_ready;
  logic [1:0]              b_resp;
  logic                    b_valid;
  logic                    b_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic                    ar_valid;
  logic                    ar_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    output aw_addr, aw_valid, w_data, w_strb, w_valid,
    output ar_addr, ar_valid, b_ready, r_ready,
    input  aw_ready, w_ready, ar_ready,
    input  b_resp, b_valid, r_data, r_resp, r_valid
  );

  modport slave (
    input  aw_addr, aw_valid, w_data, w_strb, w_valid,
    input  ar_addr, ar_valid, b_ready, r_ready,
    output aw_ready, w_ready, ar_ready,
    output b_resp, b_valid, r_data, r_resp, r_valid
  );
endinterface

// File: rtl/axil_reg_slice.sv
// AXI-Lite register slice: AW/W/AR always skid-buffered,
// B/R skid-buffered only when AXIL_SLICE_RESP_REG_EN is defined.
module axil_skid #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  // bit0 = main valid, bit1 = skid valid
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t       state;
  state_t       state_nx;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         in_hs;
  logic         out_hs;

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      EMPTY: if (in_hs) state_nx = ONE;
      ONE: begin
        if (in_hs && !out_hs)      state_nx = FULL;
        else if (!in_hs && out_hs) state_nx = EMPTY;
      end
      FULL:    if (out_hs) state_nx = ONE;
      default: state_nx = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = state[0];
    in_ready  = ~state[1];
    out_data  = main_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      unique case (1'b1)
        (state == FULL) && out_hs:
          main_q <= skid_q;
        in_hs && (!out_valid || out_hs):
          main_q <= in_data;
        default: ;
      endcase
      if (in_hs && out_valid && !out_ready)
        skid_q <= in_data;
    end
  end
endmodule

module axil_reg_slice #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  axi_lite_if.slave  s_axi,
  axi_lite_if.master m_axi
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef struct packed {
    logic [STRB_WIDTH-1:0] strb;
    logic [DATA_WIDTH-1:0] data;
  } w_beat_t;

  w_beat_t w_in;
  w_beat_t w_out;

  assign w_in         = {s_axi.w_strb, s_axi.w_data};
  assign m_axi.w_strb = w_out.strb;
  assign m_axi.w_data = w_out.data;

  axil_skid #(.W(ADDR_WIDTH)) u_aw (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_axi.aw_valid),
    .in_ready  (s_axi.aw_ready),
    .in_data   (s_axi.aw_addr),
    .out_valid (m_axi.aw_valid),
    .out_ready (m_axi.aw_ready),
    .out_data  (m_axi.aw_addr)
  );

  axil_skid #(.W($bits(w_beat_t))) u_w (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_axi.w_valid),
    .in_ready  (s_axi.w_ready),
    .in_data   (w_in),
    .out_valid (m_axi.w_valid),
    .out_ready (m_axi.w_ready),
    .out_data  (w_out)
  );

  axil_skid #(.W(ADDR_WIDTH)) u_ar (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_axi.ar_valid),
    .in_ready  (s_axi.ar_ready),
    .in_data   (s_axi.ar_addr),
    .out_valid (m_axi.ar_valid),
    .out_ready (m_axi.ar_ready),
    .out_data  (m_axi.ar_addr)
  );

`ifdef AXIL_SLICE_RESP_REG_EN
  typedef struct packed {
    logic [1:0]            resp;
    logic [DATA_WIDTH-1:0] data;
  } r_beat_t;

  r_beat_t r_in;
  r_beat_t r_out;

  assign r_in         = {m_axi.r_resp, m_axi.r_data};
  assign s_axi.r_resp = r_out.resp;
  assign s_axi.r_data = r_out.data;

  axil_skid #(.W(2)) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (m_axi.b_valid),
    .in_ready  (m_axi.b_ready),
    .in_data   (m_axi.b_resp),
    .out_valid (s_axi.b_valid),
    .out_ready (s_axi.b_ready),
    .out_data  (s_axi.b_resp)
  );

  axil_skid #(.W($bits(r_beat_t))) u_r (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (m_axi.r_valid),
    .in_ready  (m_axi.r_ready),
    .in_data   (r_in),
    .out_valid (s_axi.r_valid),
    .out_ready (s_axi.r_ready),
    .out_data  (r_out)
  );
`else
  assign s_axi.b_resp  = m_axi.b_resp;
  assign s_axi.b_valid = m_axi.b_valid;
  assign m_axi.b_ready = s_axi.b_ready;
  assign s_axi.r_data  = m_axi.r_data;
  assign s_axi.r_resp  = m_axi.r_resp;
  assign s_axi.r_valid = m_axi.r_valid;
  assign m_axi.r_ready = s_axi.r_ready;
`endif
endmodule

// File: tb/tb_axil_reg_slice.sv
// Scoreboard bench for axil_reg_slice with a simple AXI-Lite slave model.
// Build with/without AXIL_SLICE_RESP_REG_EN to cover both response paths.
module tb_axil_reg_slice;
  localparam logic [31:0] RMASK = 32'h5A5A_0000;
`ifdef AXIL_SLICE_RESP_REG_EN
  localparam int RT = 3;
`else
  localparam int RT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_axi ();
  axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_axi ();

  axil_reg_slice #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_axi (s_axi),
    .m_axi (m_axi)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [31:0] exp_aw[$];
  logic [35:0] exp_w[$];
  logic [31:0] exp_ar[$];
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  int          ar_hs_cyc[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int          ar_in = 0;
  int          ar_out = 0;
  bit          aw_stall = 0;
  logic [31:0] aw_held = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      ar_in = 0;
      ar_out = 0;
      aw_stall = 0;
    end else begin
      if (aw_stall) begin
        chk("aw_stall_valid", m_axi.aw_valid, 1);
        chk("aw_stall_addr", m_axi.aw_addr, aw_held);
      end
      aw_stall = m_axi.aw_valid && !m_axi.aw_ready;
      aw_held  = m_axi.aw_addr;
      chk("ar_ready_occ", s_axi.ar_ready, (ar_in - ar_out) < 2);
      if (s_axi.ar_valid && s_axi.ar_ready) ar_in++;
      if (m_axi.ar_valid && m_axi.ar_ready) begin
        ar_out++;
        ar_hs_cyc.push_back(cyc);
        if (exp_ar.size() == 0) chk("ar_extra", exp_ar.size(), 1);
        else chk("ar_addr", m_axi.ar_addr, exp_ar.pop_front());
      end
      if (m_axi.aw_valid && m_axi.aw_ready) begin
        if (exp_aw.size() == 0) chk("aw_extra", exp_aw.size(), 1);
        else chk("aw_addr", m_axi.aw_addr, exp_aw.pop_front());
      end
      if (m_axi.w_valid && m_axi.w_ready) begin
        if (exp_w.size() == 0) chk("w_extra", exp_w.size(), 1);
        else chk("w_beat", {m_axi.w_strb, m_axi.w_data}, exp_w.pop_front());
      end
      if (s_axi.b_valid && s_axi.b_ready) begin
        if (exp_b.size() == 0) chk("b_extra", exp_b.size(), 1);
        else chk("b_resp", s_axi.b_resp, exp_b.pop_front());
      end
      if (s_axi.r_valid && s_axi.r_ready) begin
        if (exp_r.size() == 0) chk("r_extra", exp_r.size(), 1);
        else chk("r_beat", {s_axi.r_resp, s_axi.r_data}, exp_r.pop_front());
      end
    end
  end

  // ---------------- slave model ----------------
  logic [31:0] sl_awq[$];
  logic [1:0]  sl_bq[$];
  logic [31:0] sl_rq[$];
  int          sl_wcnt = 0;
  bit          sl_awh, sl_wh, sl_bh, sl_arh, sl_rh;
  logic [31:0] sl_awa, sl_ara, sl_tmp;

  initial begin
    m_axi.b_valid = 0;
    m_axi.b_resp  = '0;
    m_axi.r_valid = 0;
    m_axi.r_data  = '0;
    m_axi.r_resp  = '0;
    forever begin
      @(negedge clk);
      sl_awh = m_axi.aw_valid && m_axi.aw_ready;
      sl_awa = m_axi.aw_addr;
      sl_wh  = m_axi.w_valid && m_axi.w_ready;
      sl_bh  = m_axi.b_valid && m_axi.b_ready;
      sl_arh = m_axi.ar_valid && m_axi.ar_ready;
      sl_ara = m_axi.ar_addr;
      sl_rh  = m_axi.r_valid && m_axi.r_ready;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        sl_awq.delete();
        sl_bq.delete();
        sl_rq.delete();
        sl_wcnt = 0;
      end else begin
        if (sl_bh) void'(sl_bq.pop_front());
        if (sl_rh) void'(sl_rq.pop_front());
        if (sl_awh) sl_awq.push_back(sl_awa);
        if (sl_wh) sl_wcnt++;
        if (sl_awq.size() > 0 && sl_wcnt > 0) begin
          sl_tmp = sl_awq.pop_front();
          sl_bq.push_back(sl_tmp[3:2]);
          sl_wcnt--;
        end
        if (sl_arh) sl_rq.push_back(sl_ara);
      end
      m_axi.b_valid = sl_bq.size() > 0;
      m_axi.b_resp  = sl_bq.size() > 0 ? sl_bq[0] : 2'b00;
      m_axi.r_valid = sl_rq.size() > 0;
      m_axi.r_data  = sl_rq.size() > 0 ? (sl_rq[0] ^ RMASK) : 32'h0;
      m_axi.r_resp  = sl_rq.size() > 0 ? sl_rq[0][3:2] : 2'b00;
    end
  end

  // ---------------- upstream drivers ----------------
  task automatic send_wr(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] st, input bit do_aw,
                         input bit do_w, output int hs_cyc);
    bit ad, wd;
    int n;
    ad = !do_aw;
    wd = !do_w;
    n = 0;
    hs_cyc = cyc;
    if (do_aw) begin
      s_axi.aw_addr  = a;
      s_axi.aw_valid = 1;
      exp_aw.push_back(a);
      exp_b.push_back(a[3:2]);
    end
    if (do_w) begin
      s_axi.w_data  = d;
      s_axi.w_strb  = st;
      s_axi.w_valid = 1;
      exp_w.push_back({st, d});
    end
    while (!(ad && wd) && n < 50) begin
      @(negedge clk);
      n++;
      hs_cyc = cyc;
      if (!ad && s_axi.aw_ready) ad = 1;
      if (!wd && s_axi.w_ready) wd = 1;
      @(posedge clk);
      #1;
      if (ad) s_axi.aw_valid = 0;
      if (wd) s_axi.w_valid = 0;
    end
    if (!(ad && wd)) chk("wr_timeout", ad && wd, 1);
  endtask

  task automatic send_ar(input logic [31:0] a, output int hs_cyc);
    bit ok;
    int n;
    ok = 0;
    n = 0;
    hs_cyc = cyc;
    s_axi.ar_addr  = a;
    s_axi.ar_valid = 1;
    exp_ar.push_back(a);
    exp_r.push_back({a[3:2], a ^ RMASK});
    while (!ok && n < 50) begin
      @(negedge clk);
      n++;
      ok = s_axi.ar_ready;
      hs_cyc = cyc;
    end
    if (!ok) chk("ar_timeout", ok, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(input bit is_r, input int t0, input int lat,
                           input string nm);
    bit got;
    int n;
    got = 0;
    n = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      got = is_r ? (s_axi.r_valid && s_axi.r_ready)
                 : (s_axi.b_valid && s_axi.b_ready);
    end
    if (got) chk(nm, cyc - t0, lat);
    else chk({nm, "_timeout"}, got, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  bit done = 0;

  initial begin
    int t;
    int prev;
    int base;
    t = 0;
    prev = 0;
    s_axi.aw_addr = '0; s_axi.aw_valid = 0;
    s_axi.w_data = '0;  s_axi.w_strb = '0; s_axi.w_valid = 0;
    s_axi.ar_addr = '0; s_axi.ar_valid = 0;
    s_axi.b_ready = 1;  s_axi.r_ready = 1;
    m_axi.aw_ready = 1; m_axi.w_ready = 1; m_axi.ar_ready = 1;
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_aw_ready", s_axi.aw_ready, 1);
    chk("rst_w_ready", s_axi.w_ready, 1);
    chk("rst_ar_ready", s_axi.ar_ready, 1);
    chk("rst_aw_valid", m_axi.aw_valid, 0);
    chk("rst_w_valid", m_axi.w_valid, 0);
    chk("rst_ar_valid", m_axi.ar_valid, 0);
    chk("rst_b_valid", s_axi.b_valid, 0);
    chk("rst_r_valid", s_axi.r_valid, 0);
    chk("rst_b_ready", m_axi.b_ready, 1);
    chk("rst_r_ready", m_axi.r_ready, 1);
    #2 rst_n = 1;
    @(posedge clk);
    #1;

    // single write
    send_wr(32'h10, 32'hDEAD_BEEF, 4'hF, 1, 1, t);
    @(negedge clk);
    chk("t1_aw_valid_lat", m_axi.aw_valid, 1);
    chk("t1_w_valid_lat", m_axi.w_valid, 1);
    wait_resp(0, t, RT, "t1_wr_roundtrip");

    // single read, then 16-beat stream
    send_ar(32'h40, t);
    s_axi.ar_valid = 0;
    wait_resp(1, t, RT, "t2_rd_roundtrip");
    base = ar_hs_cyc.size();
    for (int i = 0; i < 16; i++) begin
      send_ar(i * 4, t);
      if (i > 0) chk("t2_ar_up_gap", t - prev, 1);
      prev = t;
    end
    s_axi.ar_valid = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("t2_ar_down_cnt", ar_hs_cyc.size() - base, 16);
    if (ar_hs_cyc.size() >= base + 16)
      chk("t2_ar_down_span", ar_hs_cyc[base+15] - ar_hs_cyc[base], 15);

    // AW backpressure
    m_axi.aw_ready = 0;
    send_wr(32'h100, 32'h0, 4'h0, 1, 0, t);
    send_wr(32'h104, 32'h0, 4'h0, 1, 0, t);
    fork
      send_wr(32'h108, 32'h0, 4'h0, 1, 0, t);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("t3_aw_full_ready", s_axi.aw_ready, 0);
        end
        @(posedge clk);
        #1;
        m_axi.aw_ready = 1;
      end
    join
    send_wr(32'h0, 32'h1111_0001, 4'h1, 0, 1, t);
    send_wr(32'h0, 32'h2222_0002, 4'h3, 0, 1, t);
    send_wr(32'h0, 32'h3333_0003, 4'hF, 0, 1, t);
    repeat (6) @(posedge clk);
    #1;

    // AR stream with toggling downstream ready
    done = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) send_ar(32'h300 + i * 4, t);
        s_axi.ar_valid = 0;
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          m_axi.ar_ready = !m_axi.ar_ready;
        end
      end
    join
    m_axi.ar_ready = 1;
    repeat (6) @(posedge clk);
    #1;

    // reset with AW full and R pending
    s_axi.r_ready = 0;
    send_ar(32'h500, t);
    s_axi.ar_valid = 0;
    m_axi.aw_ready = 0;
    send_wr(32'h400, 32'h0, 4'h0, 1, 0, t);
    send_wr(32'h404, 32'h0, 4'h0, 1, 0, t);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t5_pre_aw_ready", s_axi.aw_ready, 0);
    chk("t5_pre_aw_valid", m_axi.aw_valid, 1);
`ifdef AXIL_SLICE_RESP_REG_EN
    chk("t5_pre_r_valid", s_axi.r_valid, 1);
`endif
    #2 rst_n = 0;
    #1;
    chk("t5_rst_aw_ready", s_axi.aw_ready, 1);
    chk("t5_rst_w_ready", s_axi.w_ready, 1);
    chk("t5_rst_ar_ready", s_axi.ar_ready, 1);
    chk("t5_rst_aw_valid", m_axi.aw_valid, 0);
    chk("t5_rst_w_valid", m_axi.w_valid, 0);
    chk("t5_rst_ar_valid", m_axi.ar_valid, 0);
`ifdef AXIL_SLICE_RESP_REG_EN
    chk("t5_rst_r_valid", s_axi.r_valid, 0);
    chk("t5_rst_b_valid", s_axi.b_valid, 0);
    chk("t5_rst_r_ready", m_axi.r_ready, 1);
`endif
    exp_aw.delete();
    exp_w.delete();
    exp_ar.delete();
    exp_b.delete();
    exp_r.delete();
    m_axi.aw_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1;
    s_axi.r_ready = 1;
    @(posedge clk);
    #1;
    send_wr(32'h200, 32'hCAFE_0200, 4'hF, 1, 1, t);
    wait_resp(0, t, RT, "t5_wr_roundtrip");

    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("end_aw_q", exp_aw.size(), 0);
    chk("end_w_q", exp_w.size(), 0);
    chk("end_ar_q", exp_ar.size(), 0);
    chk("end_b_q", exp_b.size(), 0);
    chk("end_r_q", exp_r.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
